whack_game_core: RTL and testbench
==================================

WHACK_GAME_CORE -- requirements
Module: whack_game_core

Interface
REQ-001 The block SHALL have parameter NUM_HOLES, default 5, meaning the number of mole positions (legal range 2..16).
REQ-002 The block SHALL have parameter TICK_DIV, default 100_000_000, meaning clk cycles per game second.
REQ-003 The block SHALL have parameter COUNTDOWN_SEC, default 3, meaning the pre-game countdown length in seconds.
REQ-004 The block SHALL have parameter GAME_SEC, default 30, meaning the play-phase length in seconds (at most 63).
REQ-005 The block SHALL have parameters LED_TICKS_EASY/MED/HARD, defaults 300_000_000/200_000_000/100_000_000, meaning mole-lit time in clk cycles per level.
REQ-006 The block SHALL have parameter GAP_TICKS, default 25_000_000, meaning dark time between moles.
REQ-007 The block SHALL have parameter MAX_SCORE, default 99, meaning the saturation value for score and miss_count.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-009 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 The block SHALL have ports start_pulse, clear_pulse, level_pulse and hammer_pulse, input, 1 bit each: single-cycle debounced pulses.
REQ-011 The block SHALL have port sw, input, NUM_HOLES bits: level switches, one per hole, already synchronised.
REQ-012 The block SHALL have port mole_led, output, NUM_HOLES bits: one-hot lit mole, or all zero.
REQ-013 The block SHALL have ports score and miss_count, output, 7 bits each: binary counts.
REQ-014 The block SHALL have port sec_value, output, 6 bits: seconds remaining in COUNTDOWN or PLAY, 0 otherwise.
REQ-015 The block SHALL have port game_state, output, 2 bits: IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3.
REQ-016 The block SHALL have port level, output, 2 bits: 0=easy, 1=medium, 2=hard.

Function
REQ-017 The FSM SHALL go IDLE -> COUNTDOWN on start_pulse, COUNTDOWN -> PLAY when the COUNTDOWN_SEC seconds expire, and PLAY -> OVER when the GAME_SEC seconds expire.
REQ-018 In OVER, start_pulse SHALL clear score and miss_count and enter COUNTDOWN in the same cycle; start_pulse SHALL be ignored in COUNTDOWN and PLAY.
REQ-019 clear_pulse SHALL zero score and miss_count in IDLE and OVER only, and SHALL be ignored elsewhere.
REQ-020 level_pulse SHALL step level 0->1->2->0 in IDLE only; level SHALL be held constant in all other states.
REQ-021 The seconds tick SHALL come from a counter that wraps at TICK_DIV-1; this counter SHALL restart at 0 on every state entry.
REQ-022 sec_value SHALL load COUNTDOWN_SEC or GAME_SEC on state entry and decrement on each tick; the state SHALL exit on the tick that takes sec_value from 1 to 0.
REQ-023 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL advance every cycle.
REQ-024 Mole index SHALL be LFSR[15:0] mod NUM_HOLES; if that equals the previous index, the index SHALL be (value+1) mod NUM_HOLES.
REQ-025 In PLAY, a mole sub-FSM SHALL cycle GAP (GAP_TICKS cycles, LEDs dark) -> LIT (LED_TICKS[level] cycles, one LED on) -> GAP.
REQ-026 PLAY entry SHALL start in GAP; the mole index SHALL be latched on the GAP->LIT transition.
REQ-027 Arm flags: a bit SHALL be set on a 0->1 edge of sw[i] while mole_led[i]=1; edges on dark holes SHALL be ignored; all flags SHALL clear on every LIT exit and on every hammer_pulse.
REQ-028 A hit SHALL be hammer_pulse while LIT with the armed bit at the lit index: score +1 (saturating at MAX_SCORE), immediate transition to GAP, and LEDs dark on the next cycle.
REQ-029 A whiff SHALL be hammer_pulse in PLAY with no armed lit bit: miss_count +1 (saturating), with mole timing unaffected.
REQ-030 A timeout SHALL be the LIT timer expiring with no hit: miss_count +1 (saturating), then GAP.
REQ-031 When a hit and a timeout occur in the same cycle, the hit SHALL win and no miss SHALL be counted.
REQ-032 When PLAY ends, mole_led SHALL be zero in the same cycle the state goes to OVER, with no miss charged for the mole that was lit.
REQ-033 mole_led SHALL be zero in every state other than PLAY and is always one-hot or zero; score and miss_count SHALL change only in PLAY, apart from clears.

Reset
REQ-034 While reset=1, game_state SHALL be IDLE, level 0, score 0, miss_count 0, sec_value 0, mole_led 0, arm flags 0, LFSR 16'hACE1, and all timers 0.
REQ-035 Reset SHALL abort any phase immediately; the first post-reset action SHALL be accepted on the first clk edge after reset falls.

Verification (TICK_DIV=10, COUNTDOWN_SEC=2, GAME_SEC=4, LED_TICKS=40/30/20, GAP_TICKS=5, NUM_HOLES=5)
REQ-036 A bench SHALL apply start_pulse in IDLE and check: COUNTDOWN with sec_value=2, PLAY after 20 cycles with sec_value=4, OVER 40 cycles later with mole_led=0.
REQ-037 A bench SHALL raise sw at the lit index while LIT, then apply hammer_pulse, and check: score=1, LEDs dark next cycle, next mole lit 5 cycles later at a different index.
REQ-038 A bench SHALL apply hammer_pulse with no switch edge and check: miss_count=1 and the mole stays lit; it SHALL then let the mole expire and check miss_count=2.
REQ-039 A bench SHALL preload score to 99, score a hit, and check score stays 99; it SHALL also issue clear_pulse in PLAY and check no effect, then in OVER and check score=0.
REQ-040 A bench SHALL apply level_pulse x3 in IDLE and check level goes 1,2,0; level_pulse in PLAY SHALL leave level unchanged; in hard level the LIT time SHALL be 20 cycles.
REQ-041 A bench SHALL assert reset mid-PLAY with a mole lit and check: all outputs return to reset values asynchronously, and a start_pulse after release begins COUNTDOWN.

Source files
------------

// File: rtl/whack_game_core.sv
// Whack-a-mole game core: game-phase FSM, seconds timer, LFSR-driven mole
// placement, arm/hit/miss scoring with saturating counters.
module whack_game_core #(
  parameter int unsigned NUM_HOLES      = 5,
  parameter int unsigned TICK_DIV       = 100_000_000,
  parameter int unsigned COUNTDOWN_SEC  = 3,
  parameter int unsigned GAME_SEC       = 30,
  parameter int unsigned LED_TICKS_EASY = 300_000_000,
  parameter int unsigned LED_TICKS_MED  = 200_000_000,
  parameter int unsigned LED_TICKS_HARD = 100_000_000,
  parameter int unsigned GAP_TICKS      = 25_000_000,
  parameter int unsigned MAX_SCORE      = 99
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_pulse,
  input  logic                 clear_pulse,
  input  logic                 level_pulse,
  input  logic                 hammer_pulse,
  input  logic [NUM_HOLES-1:0] sw,
  output logic [NUM_HOLES-1:0] mole_led,
  output logic [6:0]           score,
  output logic [6:0]           miss_count,
  output logic [5:0]           sec_value,
  output logic [1:0]           game_state,
  output logic [1:0]           level
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StCountdown = 2'd1,
    StPlay      = 2'd2,
    StOver      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          tick_cnt_q;
  logic [5:0]           sec_q;
  logic [1:0]           level_q;
  logic [6:0]           score_q, miss_q;
  logic [15:0]          lfsr_q;
  logic                 mole_lit_q;
  logic [31:0]          mole_timer_q;
  logic [3:0]           mole_idx_q;
  logic [NUM_HOLES-1:0] arm_q, sw_prev_q;

  logic                 tick, sec_done, state_entry;
  logic                 in_play, play_run;
  logic [31:0]          led_ticks;
  logic                 lit_done, gap_done;
  logic                 hit, whiff, timeout, arm_clear, score_clear;
  logic [3:0]           mod_idx, cand_idx;
  logic [NUM_HOLES-1:0] lit_mask;

  assign tick        = (tick_cnt_q == 32'(TICK_DIV - 1));
  assign sec_done    = tick && (sec_q == 6'd1);
  assign state_entry = (state_d != state_q);
  assign in_play     = (state_q == StPlay);
  // PLAY continues into the next cycle; mole logic resets whenever this is false
  assign play_run    = in_play && (state_d == StPlay);

  // Game phase state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Game phase next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_pulse) state_d = StCountdown;
      StCountdown: if (sec_done)    state_d = StPlay;
      StPlay:      if (sec_done)    state_d = StOver;
      StOver:      if (start_pulse) state_d = StCountdown;
      default:     state_d = StIdle;
    endcase
  end

  // Phase outputs: visible state and the lit mole LED
  always_comb begin
    game_state = state_q;
    mole_led   = (in_play && mole_lit_q) ? lit_mask : '0;
  end

  // Seconds prescaler and remaining-seconds counter, both reloaded on phase entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sec_q      <= '0;
    end else if (state_entry) begin
      tick_cnt_q <= '0;
      case (state_d)
        StCountdown: sec_q <= 6'(COUNTDOWN_SEC);
        StPlay:      sec_q <= 6'(GAME_SEC);
        default:     sec_q <= '0;
      endcase
    end else if (state_q == StCountdown || state_q == StPlay) begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 32'd1;
      if (tick) sec_q <= sec_q - 6'd1;
    end
  end

  // Difficulty level steps only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= '0;
    else if (state_q == StIdle && level_pulse) level_q <= (level_q == 2'd2) ? 2'd0 : level_q + 2'd1;
  end

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Candidate mole index, nudged forward so the same hole never lights twice in a row
  always_comb begin
    cand_idx = mod_idx;
    if (cand_idx == mole_idx_q) begin
      cand_idx = (cand_idx == 4'(NUM_HOLES - 1)) ? 4'd0 : cand_idx + 4'd1;
    end
  end

  assign mod_idx  = 4'(lfsr_q % 16'(NUM_HOLES));
  assign lit_mask = {{(NUM_HOLES-1){1'b0}}, 1'b1} << mole_idx_q;

  // Lit time for the current level
  always_comb begin
    case (level_q)
      2'd0:    led_ticks = 32'(LED_TICKS_EASY);
      2'd1:    led_ticks = 32'(LED_TICKS_MED);
      default: led_ticks = 32'(LED_TICKS_HARD);
    endcase
  end

  assign lit_done    = mole_lit_q && (mole_timer_q == led_ticks - 32'd1);
  assign gap_done    = !mole_lit_q && (mole_timer_q == 32'(GAP_TICKS - 1));
  assign hit         = in_play && mole_lit_q && hammer_pulse && |(arm_q & lit_mask);
  assign whiff       = in_play && hammer_pulse && !hit;
  // A mole still lit when the game ends is not charged
  assign timeout     = play_run && lit_done && !hit;
  assign arm_clear   = !play_run || hammer_pulse || lit_done;
  assign score_clear = ((state_q == StIdle || state_q == StOver) && clear_pulse) ||
                       (state_q == StOver && start_pulse);

  // Mole sub-FSM: GAP -> LIT -> GAP, index latched on entering LIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mole_lit_q   <= 1'b0;
      mole_timer_q <= '0;
      mole_idx_q   <= '0;
    end else if (!play_run || hit) begin
      mole_lit_q   <= 1'b0;
      mole_timer_q <= '0;
    end else if (mole_lit_q) begin
      if (lit_done) begin
        mole_lit_q   <= 1'b0;
        mole_timer_q <= '0;
      end else begin
        mole_timer_q <= mole_timer_q + 32'd1;
      end
    end else if (gap_done) begin
      mole_lit_q   <= 1'b1;
      mole_timer_q <= '0;
      mole_idx_q   <= cand_idx;
    end else begin
      mole_timer_q <= mole_timer_q + 32'd1;
    end
  end

  // Arm flags: rising switch edge on the lit hole arms it; any hammer or LIT exit disarms
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q     <= '0;
      sw_prev_q <= '0;
    end else begin
      arm_q     <= arm_clear ? '0 : (arm_q | (sw & ~sw_prev_q & mole_led));
      sw_prev_q <= sw;
    end
  end

  // Saturating score and miss counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      miss_q  <= '0;
    end else if (score_clear) begin
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      if (hit && score_q != 7'(MAX_SCORE)) score_q <= score_q + 7'd1;
      if ((whiff || timeout) && miss_q != 7'(MAX_SCORE)) miss_q <= miss_q + 7'd1;
    end
  end

  assign score      = score_q;
  assign miss_count = miss_q;
  assign sec_value  = sec_q;
  assign level      = level_q;

endmodule

// File: tb/tb_whack_game_core.sv
// Bench for whack_game_core: per-cycle behavioural model plus directed scenarios.
module tb_whack_game_core;

  localparam int N    = 5;
  localparam int TD   = 10;
  localparam int CDS  = 2;
  localparam int GS   = 4;
  localparam int GAP  = 5;
  localparam int MAXS = 99;
  localparam int MAXT = 1;

  logic clk = 1'b0, reset = 1'b0;
  logic start_pulse = 1'b0, clear_pulse = 1'b0, level_pulse = 1'b0, hammer_pulse = 1'b0;
  logic [N-1:0] sw = '0;

  logic [N-1:0] mole_led, s_mole_led;
  logic [6:0]   score, miss_count, s_score, s_miss;
  logic [5:0]   sec_value, s_sec;
  logic [1:0]   game_state, level, s_state, s_level;

  int checks = 0, failures = 0, cyc = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  whack_game_core #(
    .NUM_HOLES(N), .TICK_DIV(TD), .COUNTDOWN_SEC(CDS), .GAME_SEC(GS),
    .LED_TICKS_EASY(40), .LED_TICKS_MED(30), .LED_TICKS_HARD(20),
    .GAP_TICKS(GAP), .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk), .reset(reset), .start_pulse(start_pulse), .clear_pulse(clear_pulse),
    .level_pulse(level_pulse), .hammer_pulse(hammer_pulse), .sw(sw), .mole_led(mole_led),
    .score(score), .miss_count(miss_count), .sec_value(sec_value),
    .game_state(game_state), .level(level)
  );

  // Same stimulus, tiny saturation limit
  whack_game_core #(
    .NUM_HOLES(N), .TICK_DIV(TD), .COUNTDOWN_SEC(CDS), .GAME_SEC(GS),
    .LED_TICKS_EASY(40), .LED_TICKS_MED(30), .LED_TICKS_HARD(20),
    .GAP_TICKS(GAP), .MAX_SCORE(MAXT)
  ) u_sat (
    .clk(clk), .reset(reset), .start_pulse(start_pulse), .clear_pulse(clear_pulse),
    .level_pulse(level_pulse), .hammer_pulse(hammer_pulse), .sw(sw), .mole_led(s_mole_led),
    .score(s_score), .miss_count(s_miss), .sec_value(s_sec),
    .game_state(s_state), .level(s_level)
  );

  // ---------------- behavioural model ----------------
  // m_tleft: cycles to next second tick; m_left: cycles left in current GAP/LIT phase.
  int          m_state, m_level, m_sec, m_tleft, m_left, m_idx, m_raw_score, m_raw_miss;
  bit          m_lit;
  bit [15:0]   m_lfsr;
  bit [N-1:0]  m_arm, m_swp;

  function automatic int led_time(input int lv);
    return (lv == 0) ? 40 : (lv == 1) ? 30 : 20;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0] v;
    v = '0;
    if (m_state == 2 && m_lit) v[m_idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_sec = 0; m_tleft = TD; m_left = GAP; m_idx = 0;
    m_raw_score = 0; m_raw_miss = 0; m_lit = 1'b0; m_lfsr = 16'hACE1;
    m_arm = '0; m_swp = '0;
  endtask

  task automatic model_step();
    int nstate, cand;
    bit hit, miss, lit_exit;
    bit [N-1:0] led, rise;
    led = exp_led();
    rise = sw & ~m_swp;
    nstate = m_state; hit = 1'b0; miss = 1'b0; lit_exit = 1'b0;
    case (m_state)
      0: begin
        if (start_pulse) nstate = 1;
        if (clear_pulse) begin m_raw_score = 0; m_raw_miss = 0; end
        if (level_pulse) m_level = (m_level + 1) % 3;
      end
      3: begin
        if (start_pulse || clear_pulse) begin m_raw_score = 0; m_raw_miss = 0; end
        if (start_pulse) nstate = 1;
      end
      default: begin
        m_tleft--;
        if (m_tleft == 0) begin
          m_tleft = TD;
          m_sec--;
          if (m_sec == 0) nstate = m_state + 1;
        end
      end
    endcase
    if (m_state == 2) begin
      hit  = hammer_pulse && m_lit && m_arm[m_idx];
      miss = hammer_pulse && !hit;
      if (nstate != 2) begin
        m_lit = 1'b0;
      end else if (hit) begin
        m_lit = 1'b0; m_left = GAP;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_lit) begin
            miss = 1'b1; m_lit = 1'b0; m_left = GAP; lit_exit = 1'b1;
          end else begin
            cand = int'(m_lfsr) % N;
            if (cand == m_idx) cand = (cand + 1) % N;
            m_idx = cand; m_lit = 1'b1; m_left = led_time(m_level);
          end
        end
      end
      if (hammer_pulse || lit_exit || nstate != 2) m_arm = '0;
      else m_arm = m_arm | (rise & led);
      if (hit)  m_raw_score++;
      if (miss) m_raw_miss++;
    end
    if (nstate != m_state) begin
      m_tleft = TD;
      m_sec = (nstate == 1) ? CDS : (nstate == 2) ? GS : 0;
      if (nstate == 2) begin m_lit = 1'b0; m_left = GAP; m_arm = '0; end
    end
    m_state = nstate;
    m_swp = sw;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_state",  int'(game_state), m_state);
      check("m_level",  int'(level),      m_level);
      check("m_sec",    int'(sec_value),  m_sec);
      check("m_led",    int'(mole_led),   int'(exp_led()));
      check("m_score",  int'(score),      imin(m_raw_score, MAXS));
      check("m_miss",   int'(miss_count), imin(m_raw_miss, MAXS));
      check("s_state",  int'(s_state),    m_state);
      check("s_level",  int'(s_level),    m_level);
      check("s_sec",    int'(s_sec),      m_sec);
      check("s_led",    int'(s_mole_led), int'(exp_led()));
      check("s_score",  int'(s_score),    imin(m_raw_score, MAXT));
      check("s_miss",   int'(s_miss),     imin(m_raw_miss, MAXT));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
    #1;
  endtask

  // 0 start, 1 clear, 2 level, 3 hammer
  task automatic do_pulse(input int kind);
    case (kind)
      0: start_pulse  = 1'b1;
      1: clear_pulse  = 1'b1;
      2: level_pulse  = 1'b1;
      default: hammer_pulse = 1'b1;
    endcase
    tick_n(1);
    start_pulse = 1'b0; clear_pulse = 1'b0; level_pulse = 1'b0; hammer_pulse = 1'b0;
  endtask

  task automatic wait_lit(input string name);
    int n;
    n = 0;
    while (mole_led == '0 && n < 60) begin
      tick_n(1);
      n++;
    end
    check(name, int'(mole_led != '0), 1);
  endtask

  task automatic wait_state(input int st, input string name);
    int n;
    n = 0;
    while (int'(game_state) != st && n < 60) begin
      tick_n(1);
      n++;
    end
    check(name, int'(game_state), st);
  endtask

  // Arm the lit hole, then hammer it on the following cycle
  task automatic do_hit();
    sw = mole_led;
    tick_n(1);
    do_pulse(3);
    sw = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, int'(game_state), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_miss"},  int'(miss_count), 0);
    check({tag, "_sec"},   int'(sec_value), 0);
    check({tag, "_led"},   int'(mole_led), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p_cyc;
    logic [N-1:0] prev;

    #1 reset = 1'b1; cmp_en = 1'b1;
    #1 check_reset_outputs("rst");
    tick_n(2);

    // Level stepping in IDLE; first pulse lands on the first edge after release
    reset = 1'b0;
    do_pulse(2); check("level_1", int'(level), 1);
    do_pulse(2); check("level_2", int'(level), 2);
    do_pulse(2); check("level_0", int'(level), 0);
    do_pulse(2); do_pulse(2); check("level_hard", int'(level), 2);

    // Game 1: phase timing
    do_pulse(0);
    check("cd_state", int'(game_state), 1);
    check("cd_sec", int'(sec_value), 2);
    tick_n(19);
    check("cd_state_19", int'(game_state), 1);
    check("cd_sec_19", int'(sec_value), 1);
    tick_n(1);
    p_cyc = cyc;
    check("play_state", int'(game_state), 2);
    check("play_sec", int'(sec_value), 4);

    // Level and start ignored in PLAY
    level_pulse = 1'b1; start_pulse = 1'b1;
    tick_n(1);
    level_pulse = 1'b0; start_pulse = 1'b0;
    check("level_held", int'(level), 2);
    check("start_ignored", int'(game_state), 2);

    // Whiff keeps the mole lit; then let it time out (hard = 20 cycles lit)
    wait_lit("lit1");
    n = 1;
    do_pulse(3);
    n++;
    check("whiff_miss", int'(miss_count), 1);
    check("whiff_stays_lit", int'(mole_led != '0), 1);
    while (n < 60) begin
      tick_n(1);
      if (mole_led == '0) break;
      n++;
    end
    check("lit_time_hard", n, 20);
    check("timeout_miss", int'(miss_count), 2);

    // Hit
    wait_lit("lit2");
    prev = mole_led;
    do_hit();
    check("hit_score", int'(score), 1);
    check("hit_dark", int'(mole_led), 0);
    do_pulse(1);
    check("clear_in_play_score", int'(score), 1);
    check("clear_in_play_miss", int'(miss_count), 2);
    n = 0;
    while (mole_led == '0 && n < 20) begin
      tick_n(1);
      n++;
    end
    check("gap_after_hit", n, 4);
    check("new_index", int'(mole_led != prev && mole_led != '0), 1);

    // Game end with a mole lit: dark, no miss
    wait_state(3, "over_state");
    check("play_len", cyc - p_cyc, 40);
    check("over_led", int'(mole_led), 0);
    check("over_sec", int'(sec_value), 0);
    check("over_miss", int'(miss_count), 2);
    check("sat_miss", int'(s_miss), 1);
    do_pulse(1);
    check("clear_over_score", int'(score), 0);
    check("clear_over_miss", int'(miss_count), 0);

    // Game 2: two hits saturate the MAX_SCORE=1 instance, then reset mid-mole
    do_pulse(0);
    check("cd2_state", int'(game_state), 1);
    wait_state(2, "play2_state");
    wait_lit("lit4");
    do_hit();
    check("hit2_score", int'(score), 1);
    wait_lit("lit5");
    do_hit();
    check("hit3_score", int'(score), 2);
    check("sat_score", int'(s_score), 1);
    wait_lit("lit6");
    reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    tick_n(2);
    reset = 1'b0;
    do_pulse(0);
    check("post_rst_state", int'(game_state), 1);
    check("post_rst_sec", int'(sec_value), 2);
    tick_n(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
